// File: rtl/minmax_pkg.sv
// Shared types for the window min/max tracker: FSM states, comparator result, count width.
package minmax_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_res_t;

  // Wide enough to hold a full-window count of WINDOW samples.
  function automatic int cnt_width(input int window);
    return $clog2(window + 1);
  endfunction

endpackage

// File: rtl/window_minmax_tracker_mag_comparator.sv
// Unsigned magnitude comparator: a vs b -> {gt, lt, eq}.
// Purely combinational, zero latency, no flow control.
module mag_comparator
  import minmax_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output cmp_res_t         o_res
);

  always_comb begin
    o_res.gt = (i_a > i_b);
    o_res.lt = (i_a < i_b);
    o_res.eq = (i_a == i_b);
  end

endmodule

// File: rtl/window_minmax_tracker.sv
// Per-window max/min/count of an unsigned stream; result valid the cycle after the closing sample.
// Backpressure: in_ready drops while a result waits in HOLD for out_ready; MINMAX_ARGIDX_EN adds argmax/argmin.
module window_minmax_tracker
  import minmax_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int WINDOW = 16,
  localparam int CNT_W  = cnt_width(WINDOW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [CNT_W-1:0] out_count
`ifdef MINMAX_ARGIDX_EN
  ,
  output logic [CNT_W-1:0] out_max_idx,
  output logic [CNT_W-1:0] out_min_idx
`endif
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_max;
  logic [WIDTH-1:0] r_min;
  logic [CNT_W-1:0] r_count;
  logic             w_xfer;
  cmp_res_t         w_cmp_max;
  cmp_res_t         w_cmp_min;
  logic             w_unused;

  mag_comparator #(.WIDTH(WIDTH)) u_cmp_max (
    .i_a  (in_data),
    .i_b  (r_max),
    .o_res(w_cmp_max)
  );

  mag_comparator #(.WIDTH(WIDTH)) u_cmp_min (
    .i_a  (in_data),
    .i_b  (r_min),
    .o_res(w_cmp_min)
  );

  // Strict compares keep the first occurrence; the remaining flags are not needed.
  assign w_unused = &{1'b0, w_cmp_max.lt, w_cmp_max.eq, w_cmp_min.gt, w_cmp_min.eq};

  always_comb begin
    w_xfer = in_valid & r_in_ready;
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_xfer) w_next = (in_last || (WINDOW == 1)) ? HOLD : ACCUM;
      ACCUM:   if (w_xfer && (in_last || (r_count == LAST_IDX))) w_next = HOLD;
      HOLD:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_max       <= '0;
      r_min       <= '0;
      r_count     <= '0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next != HOLD);
      r_out_valid <= (w_next == HOLD);
      if (w_xfer) begin
        if (r_state == IDLE) begin
          r_max   <= in_data;
          r_min   <= in_data;
          r_count <= CNT_W'(1);
        end else begin
          if (w_cmp_max.gt) r_max <= in_data;
          if (w_cmp_min.lt) r_min <= in_data;
          r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

`ifdef MINMAX_ARGIDX_EN
  logic [CNT_W-1:0] r_max_idx;
  logic [CNT_W-1:0] r_min_idx;

  // r_count equals the 0-based position of the sample being accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max_idx <= '0;
      r_min_idx <= '0;
    end else if (w_xfer) begin
      if (r_state == IDLE) begin
        r_max_idx <= '0;
        r_min_idx <= '0;
      end else begin
        if (w_cmp_max.gt) r_max_idx <= r_count;
        if (w_cmp_min.lt) r_min_idx <= r_count;
      end
    end
  end

  assign out_max_idx = r_max_idx;
  assign out_min_idx = r_min_idx;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_max   = r_max;
  assign out_min   = r_min;
  assign out_count = r_count;

endmodule

// File: tb/tb_window_minmax_tracker.sv
// Scoreboard bench: three trackers (WINDOW 4, 16, 1) with directed windows and hand-computed results.
module tb_window_minmax_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [2:0]      in_valid, in_last, out_ready, in_ready, out_valid;
  logic [2:0][7:0] in_data, o_max, o_min;
  logic [2:0][4:0] o_cnt;
`ifdef MINMAX_ARGIDX_EN
  logic [2:0][4:0] o_max_idx, o_min_idx;
`endif

  typedef struct {
    logic [7:0] mx;
    logic [7:0] mn;
    logic [4:0] cnt;
    logic [4:0] mxi;
    logic [4:0] mni;
  } exp_t;

  exp_t sbq[3][$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W  = (g == 0) ? 4 : ((g == 1) ? 16 : 1);
    localparam int CW = $clog2(W + 1);
    logic [CW-1:0] cnt;
`ifdef MINMAX_ARGIDX_EN
    logic [CW-1:0] mxi, mni;
`endif

    window_minmax_tracker #(.WIDTH(8), .WINDOW(W)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_data  (in_data[g]),
      .in_last  (in_last[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_max  (o_max[g]),
      .out_min  (o_min[g]),
      .out_count(cnt)
`ifdef MINMAX_ARGIDX_EN
      ,
      .out_max_idx(mxi),
      .out_min_idx(mni)
`endif
    );

    assign o_cnt[g] = 5'(cnt);
`ifdef MINMAX_ARGIDX_EN
    assign o_max_idx[g] = 5'(mxi);
    assign o_min_idx[g] = 5'(mni);
`endif

    initial begin : mon
      exp_t e;
      forever begin
        @(negedge clk);
        #1;
        if (rst_n && out_valid[g] && out_ready[g]) begin
          if (sbq[g].size() == 0) begin
            chk($sformatf("unexpected_result_dut%0d", g), 1, 0);
          end else begin
            e = sbq[g].pop_front();
            chk($sformatf("max_dut%0d", g), o_max[g], e.mx);
            chk($sformatf("min_dut%0d", g), o_min[g], e.mn);
            chk($sformatf("count_dut%0d", g), o_cnt[g], e.cnt);
`ifdef MINMAX_ARGIDX_EN
            chk($sformatf("max_idx_dut%0d", g), o_max_idx[g], e.mxi);
            chk($sformatf("min_idx_dut%0d", g), o_min_idx[g], e.mni);
`endif
          end
        end
      end
    end
  end

  task automatic push(input int g, input int mx, input int mn, input int cnt,
                      input int mxi, input int mni);
    exp_t e;
    e.mx  = 8'(mx);
    e.mn  = 8'(mn);
    e.cnt = 5'(cnt);
    e.mxi = 5'(mxi);
    e.mni = 5'(mni);
    sbq[g].push_back(e);
  endtask

  // Called just after a negedge; returns just after the negedge following the transfer.
  task automatic send(input int g, input int d, input bit last);
    int n = 0;
    in_valid[g] = 1'b1;
    in_data[g]  = 8'(d);
    in_last[g]  = last;
    while (!in_ready[g] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk($sformatf("send_timeout_dut%0d", g), 0, 1);
    @(negedge clk);
    in_valid[g] = 1'b0;
    in_last[g]  = 1'b0;
  endtask

  task automatic chk_lat(input int g);
    chk($sformatf("lat_out_valid_dut%0d", g), out_valid[g], 1);
    chk($sformatf("lat_in_ready_dut%0d", g), in_ready[g], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 3'b111;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_max", o_max, 0);
    chk("rst_min", o_min, 0);
    chk("rst_count", o_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 3'b111);

    // Window closed by count.
    push(0, 9, 2, 4, 1, 2);
    send(0, 5, 0); send(0, 9, 0); send(0, 2, 0); send(0, 7, 0);
    chk_lat(0);

    // Equal samples: first occurrence stays.
    push(0, 3, 3, 4, 0, 0);
    send(0, 3, 0); send(0, 3, 0); send(0, 3, 0); send(0, 3, 0);
    chk_lat(0);

    push(0, 7, 2, 4, 0, 1);
    send(0, 7, 0); send(0, 2, 0); send(0, 7, 0); send(0, 2, 0);
    chk_lat(0);

    // Early close on first sample, top code value.
    push(0, 255, 255, 1, 0, 0);
    send(0, 255, 1);
    chk_lat(0);

    // Early close in a long window.
    push(1, 200, 17, 2, 0, 1);
    send(1, 200, 0); send(1, 17, 1);
    chk_lat(1);

    // Stall: result held, input refused.
    out_ready[0] = 1'b0;
    push(0, 40, 10, 4, 3, 0);
    send(0, 10, 0); send(0, 20, 0); send(0, 30, 0); send(0, 40, 0);
    chk_lat(0);
    in_valid[0] = 1'b1;
    in_data[0]  = 8'd0;
    in_last[0]  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_out_valid", out_valid[0], 1);
      chk("stall_in_ready", in_ready[0], 0);
      chk("stall_max", o_max[0], 40);
      chk("stall_min", o_min[0], 10);
      chk("stall_count", o_cnt[0], 4);
    end
    in_valid[0]  = 1'b0;
    in_last[0]   = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("release_out_valid", out_valid[0], 0);
    chk("release_in_ready", in_ready[0], 1);

    // Mid-window reset.
    send(0, 100, 0); send(0, 50, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_max", o_max[0], 0);
    chk("arst_min", o_min[0], 0);
    chk("arst_count", o_cnt[0], 0);
    chk("arst_in_ready", in_ready[0], 0);
    chk("arst_out_valid", out_valid[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(0, 8, 1, 4, 2, 1);
    send(0, 4, 0); send(0, 1, 0); send(0, 8, 0); send(0, 6, 0);
    chk_lat(0);

    // Single-sample windows at both code extremes.
    push(2, 0, 0, 1, 0, 0);
    push(2, 255, 255, 1, 0, 0);
    send(2, 0, 0);
    chk_lat(2);
    send(2, 255, 0);
    chk_lat(2);

    repeat (5) @(negedge clk);
    for (int g = 0; g < 3; g++) chk($sformatf("drain_dut%0d", g), sbq[g].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
